// File: rtl/fetch_pc_ifid.sv
// Fetch-stage program counter and IF/ID pipeline register for the 5-stage MIPS core.
// PC_F addresses the instruction ROM. The fetched word, its PC and the link values
// are registered into D. Redirects come from D and honour one architectural delay slot.
module fetch_pc_ifid #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_4000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic [31:0] PC8_D,
    output logic        valid_D,
    output logic        adel_D
);

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JAL    = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    // One past the last legal fetch byte; the window is [RESET_PC, window_end).
    localparam logic [31:0] WINDOW_END = RESET_PC + IMEM_BYTES;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        adel_f;

    assign imem_addr = PC_F;
    assign pc_plus4  = PC_F + 32'd4;

    // Misaligned or out-of-window fetch addresses are flagged; compares are unsigned.
    always_comb begin
        adel_f = (PC_F[1:0] != 2'b00) || (PC_F < RESET_PC) || (PC_F >= WINDOW_END);
    end

    // Next-PC mux driven by the redirect decision made in D.
    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel)
            NPC_SEQ:    next_pc = pc_plus4;
            NPC_BRANCH: next_pc = branch_target;
            NPC_JAL:    next_pc = jal_target;
            NPC_JR:     next_pc = jr_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    // PC and IF/ID update: reset, then flush, then stall hold, else advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            PC_F    <= RESET_PC;
            Instr_D <= NOP_INSTR;
            PC_D    <= RESET_PC;
            PC4_D   <= RESET_PC + 32'd4;
            PC8_D   <= RESET_PC + 32'd8;
            valid_D <= 1'b0;
            adel_D  <= 1'b0;
        end else if (flush) begin
            PC_F    <= flush_pc;
            Instr_D <= NOP_INSTR;
            PC_D    <= flush_pc;
            PC4_D   <= flush_pc + 32'd4;
            PC8_D   <= flush_pc + 32'd8;
            valid_D <= 1'b0;
            adel_D  <= 1'b0;
        end else if (!stall) begin
            PC_F    <= next_pc;
            PC_D    <= PC_F;
            PC4_D   <= pc_plus4;
            PC8_D   <= PC_F + 32'd8;
            valid_D <= 1'b1;
            if (adel_f) begin
                Instr_D <= NOP_INSTR;
                adel_D  <= 1'b1;
            end else begin
                Instr_D <= imem_rdata;
                adel_D  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Scoreboard bench for fetch_pc_ifid: a driver issues per-cycle stimulus and pushes the
// reference model's expected post-edge state; a monitor pops and compares after each edge.
module tb_fetch_pc_ifid;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BYTES = 32'h0000_4000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] OOW_WORD   = 32'hDEAD_BEEF;
    localparam int          NUM_RANDOM = 2000;

    typedef struct {
        logic [31:0] pcF;
        logic [31:0] instr;
        logic [31:0] pcD;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic        valid;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [1:0]  npc_sel;
    logic [31:0] branch_target;
    logic [31:0] jal_target;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic [31:0] PC8_D;
    logic        valid_D;
    logic        adel_D;

    logic [31:0] rom [0:4095];
    exp_t        sbq [$];
    int          checkCount = 0;
    int          passCount  = 0;

    // Reference model state: the architectural view of F and D.
    logic [31:0] mPcF;
    logic [31:0] mInstr;
    logic [31:0] mPcD;
    logic        mValid;
    logic        mAdel;

    fetch_pc_ifid #(
        .RESET_PC(RESET_PC),
        .IMEM_BYTES(IMEM_BYTES),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .flush_pc(flush_pc),
        .npc_sel(npc_sel),
        .branch_target(branch_target),
        .jal_target(jal_target),
        .jr_target(jr_target),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .PC_F(PC_F),
        .Instr_D(Instr_D),
        .PC_D(PC_D),
        .PC4_D(PC4_D),
        .PC8_D(PC8_D),
        .valid_D(valid_D),
        .adel_D(adel_D)
    );

    always #5 clk = ~clk;

    function automatic logic inWindow(input logic [31:0] a);
        longint unsigned la;
        la = longint'(a);
        return (la >= longint'(RESET_PC)) && (la < longint'(RESET_PC) + longint'(IMEM_BYTES));
    endfunction

    function automatic logic fetchError(input logic [31:0] a);
        return ((a % 4) != 0) || !inWindow(a);
    endfunction

    // Combinational ROM: in-window reads return the stored word, anything else a marker.
    always_comb begin
        imem_rdata = OOW_WORD;
        if (inWindow(imem_addr))
            imem_rdata = rom[12'((imem_addr - RESET_PC) >> 2)];
    end

    function automatic logic [31:0] modelRom(input logic [31:0] a);
        if (inWindow(a))
            return rom[12'((a - RESET_PC) / 4)];
        return OOW_WORD;
    endfunction

    function automatic logic [31:0] randTarget();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return RESET_PC + 32'($urandom_range(0, 4095)) * 4;
        if (r == 7) return RESET_PC + 32'($urandom_range(0, 16383));
        return $urandom();
    endfunction

    task automatic applyStimulus(input logic rstN, input logic fl, input logic st,
                                 input logic [1:0] sel, input logic [31:0] bt,
                                 input logic [31:0] jt, input logic [31:0] jrt,
                                 input logic [31:0] fpc);
        exp_t e;
        logic [31:0] target;
        @(negedge clk);
        reset = rstN; flush = fl; stall = st; npc_sel = sel;
        branch_target = bt; jal_target = jt; jr_target = jrt; flush_pc = fpc;
        if (!rstN) begin
            mPcF = RESET_PC; mInstr = NOP_INSTR; mPcD = RESET_PC; mValid = 0; mAdel = 0;
        end else if (fl) begin
            mPcF = fpc; mInstr = NOP_INSTR; mPcD = fpc; mValid = 0; mAdel = 0;
        end else if (!st) begin
            case (sel)
                2'd1:    target = bt;
                2'd2:    target = jt;
                2'd3:    target = jrt;
                default: target = mPcF + 4;
            endcase
            mPcD   = mPcF;
            mValid = 1;
            mAdel  = fetchError(mPcF);
            mInstr = mAdel ? NOP_INSTR : modelRom(mPcF);
            mPcF   = target;
        end
        e.pcF = mPcF; e.instr = mInstr; e.pcD = mPcD;
        e.pc4 = mPcD + 4; e.pc8 = mPcD + 8; e.valid = mValid; e.adel = mAdel;
        sbq.push_back(e);
    endtask

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act === req) passCount++;
        else $display("[TB] FAIL %s at %0t: got %08h expected %08h", name, $time, act, req);
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("PC_F", PC_F, e.pcF);
        compareField("imem_addr", imem_addr, e.pcF);
        compareField("Instr_D", Instr_D, e.instr);
        compareField("PC_D", PC_D, e.pcD);
        compareField("PC4_D", PC4_D, e.pc4);
        compareField("PC8_D", PC8_D, e.pc8);
        compareField("valid_D", 32'(valid_D), 32'(e.valid));
        compareField("adel_D", 32'(adel_D), 32'(e.adel));
    endtask

    // Monitor: after each edge, compare the DUT against the oldest expected entry.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) checkOutput(sbq.pop_front());
        end
    end

    // Driver: directed scenarios from the block's intended behaviour, then random traffic.
    initial begin
        logic [31:0] z;
        bit drained;
        z = 32'h0;
        for (int i = 0; i < 4096; i++) rom[i] = $urandom();
        rom[0] = 32'h3C01_1234;
        reset = 1; stall = 0; flush = 0; npc_sel = 0;
        flush_pc = 0; branch_target = 0; jal_target = 0; jr_target = 0;

        applyStimulus(0, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 0, 0, 2'd2, z, 32'h3100, z, z);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 2'd1, 32'h3040, z, z, z);
        applyStimulus(1, 0, 0, 2'd1, 32'h3040, z, z, z);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 1, 1, 2'd3, z, z, 32'h1234, 32'h4180);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 0, 0, 2'd3, z, z, 32'h3002, z);
        applyStimulus(1, 0, 0, 2'd3, z, z, 32'h8000, z);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 1, 0, 2'd0, z, z, z, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 0, 1, 2'd0, z, z, z, z);
        applyStimulus(0, 1, 1, 2'd3, z, z, 32'h5555, 32'h4444);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);
        applyStimulus(1, 0, 0, 2'd0, z, z, z, z);

        for (int i = 0; i < NUM_RANDOM; i++) begin
            logic [1:0] sel;
            sel = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            applyStimulus(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                          sel, randTarget(), randTarget(), randTarget(), randTarget());
        end

        drained = 0;
        for (int i = 0; i < 10 && !drained; i++) begin
            @(posedge clk);
            #2;
            if (sbq.size() == 0) drained = 1;
        end
        if (!drained) begin
            checkCount++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ifid.md
Name: fetch_pc_ifid

Overview:
- Fetch-stage program counter plus the IF/ID pipeline register for the 5-stage MIPS core.
- Holds PC_F and drives the instruction-memory address.
- Selects the next PC from PC+4, the branch target, the j/jal target or the jr target. Redirects are decided in D with one architectural delay slot.
- Registers Instr_D, PC_D, PC4_D, PC8_D and status into D. The D-stage jump-target logic and the decoder consume these.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset.
- IMEM_BYTES, 32'h0000_4000, size of the legal fetch window [RESET_PC, RESET_PC+IMEM_BYTES).
- NOP_INSTR, 32'h0000_0000, instruction word injected into D on bubble, flush or fetch error.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hazard-unit stall; freezes PC_F and the IF/ID register.
- flush  in  1  exception/eret redirect; clears D and loads flush_pc.
- flush_pc  in  32  redirect address used when flush=1.
- npc_sel  in  2  next-PC select from D: 00 PC_F+4, 01 branch, 10 j/jal, 11 jr.
- branch_target  in  32  taken-branch target computed in D.
- jal_target  in  32  {PC4_D[31:28], Instr_D[25:0], 2'b00} computed in D.
- jr_target  in  32  forwarded rs value for jr/jalr.
- imem_addr  out  32  equals PC_F (combinational).
- imem_rdata  in  32  instruction word; combinational ROM read of imem_addr.
- PC_F  out  32  current fetch PC.
- Instr_D  out  32  instruction in D.
- PC_D  out  32  PC of Instr_D.
- PC4_D  out  32  PC_D+4.
- PC8_D  out  32  PC_D+8; link value.
- valid_D  out  1  1 when D holds a real fetched instruction.
- adel_D  out  1  fetch address error for the instruction in D.

Behaviour:
- Reset (reset==0 at a rising edge):
  - PC_F=RESET_PC.
  - Instr_D=NOP_INSTR.
  - PC_D=RESET_PC; PC4_D=RESET_PC+4; PC8_D=RESET_PC+8.
  - valid_D=0; adel_D=0.
  - Reset overrides stall and flush.
  - Reset asserted mid-stream discards all in-flight state on that edge.
- Fetch error: adel_F = (PC_F[1:0]!=0) | (PC_F<RESET_PC) | (PC_F>=RESET_PC+IMEM_BYTES). The subtraction/compare is unsigned 32-bit.
- Next PC, combinational:
  - npc_sel=00: PC_F+4, 32-bit wrapping.
  - npc_sel=01: branch_target.
  - npc_sel=10: jal_target.
  - npc_sel=11: jr_target, loaded unmodified even if misaligned. The error is flagged as adel on the following fetch.
- Delay slot: when D redirects, the instruction at PC_F in the same cycle is the delay slot. It is captured into D normally, and the target is fetched next.
- Per-edge priority, reset excluded:
  1. flush=1:
     - PC_F<=flush_pc.
     - Instr_D<=NOP_INSTR, valid_D<=0, adel_D<=0.
     - PC_D<=flush_pc, with PC4_D/PC8_D derived.
     - Applies regardless of stall and npc_sel.
  2. stall=1 (flush=0):
     - PC_F and all D outputs hold.
     - npc_sel is ignored. The redirecting instruction stays in D and re-evaluates next cycle.
  3. Otherwise:
     - PC_F<=NPC.
     - PC_D<=PC_F, PC4_D<=PC_F+4, PC8_D<=PC_F+8.
     - If adel_F: Instr_D<=NOP_INSTR, adel_D<=1, valid_D<=1.
     - Else: Instr_D<=imem_rdata, adel_D<=0, valid_D<=1.
- Latency: imem_addr→Instr_D is one cycle. Redirect in D→target in F is the next edge.
- Wrap-around: PC_F=32'hFFFF_FFFC with npc_sel=00 gives PC_F=0. This is flagged adel (out of window); no other effect.
- All D outputs change only on clk edges. imem_addr is the only combinational output path.

Test Plan:
- Reset then free-run with stall=0, npc_sel=00, ROM[0x3000]=0x3C01_1234:
  - Cycle 0: PC_F=0x3000, valid_D=0.
  - Cycle 1: Instr_D=0x3C01_1234, PC_D=0x3000, PC8_D=0x3008; PC_F=0x3004.
- jal in D with npc_sel=10, jal_target=0x3100 while PC_F=0x3008:
  - Next edge: Instr_D is the 0x3008 word (delay slot), PC_F=0x3100.
  - Following edge: PC_D=0x3100.
- stall=1 for 3 cycles while D holds a beq with npc_sel=01, branch_target=0x3040:
  - PC_F and Instr_D are frozen for 3 cycles.
  - On the first unstalled edge, PC_F=0x3040.
- flush=1, flush_pc=0x4180, with stall=1 and npc_sel=11 on the same edge:
  - PC_F=0x4180, Instr_D=0, valid_D=0, adel_D=0.
- jr with jr_target=0x3002:
  - PC_F=0x3002.
  - Next edge: adel_D=1, Instr_D=NOP_INSTR, PC_D=0x3002.
  - Repeat with jr_target=0x8000: same result for the out-of-window case.
- Assert reset=0 for one edge mid-run during stall=1 and flush=1:
  - All outputs return to reset values.
  - Fetch resumes from 0x3000 on the next edge.
